spi_slave_stream: RTL and testbench
===================================

// Module: spi_slave_stream
// PURPOSE
//  Parametrised SPI slave: system-clock oversampled, all 4 SPI modes, full duplex, WORD_W-bit words.
//  Received words go into an RX FIFO with a valid/ready stream toward the command decoder.
//  TX words come from a valid/ready input and shift out on MISO.
//  Sits between the MCU SPI pins and the draw-command logic in Main; replaces the fixed 16-bit mode-0 receiver.
// PARAMETERS
//  WORD_W      16  bits per SPI word, MSB first; >=4
//  FIFO_DEPTH  8   RX FIFO entries; power of two, >=2
//  SYNC_STAGES 2   synchroniser flops on sclk/cs/mosi; >=2
//  TX_IDLE     '0  word shifted out when no TX word is offered
// PORTS
//  clock          in   1       system clock (100 MHz)
//  io_aresetn     in   1       async active-low reset
//  io_mode        in   2       {CPOL,CPHA}; sampled only while CS is high
//  io_spi_sclk    in   1       SPI clock, async
//  io_spi_cs      in   1       chip select, active low, async
//  io_spi_mosi    in   1       master-out data, async
//  io_spi_miso    out  1       slave-out data
//  io_rx_data     out  WORD_W  FIFO head word
//  io_rx_valid    out  1       FIFO not empty
//  io_rx_ready    in   1       pop when valid&ready
//  io_tx_data     in   WORD_W  next word to transmit
//  io_tx_valid    in   1       TX word offered
//  io_tx_ready    out  1       1-cycle pulse: TX word accepted
//  io_overrun     out  1       sticky: RX word dropped on full FIFO
//  io_overrun_clr in   1       clears io_overrun
//  io_busy        out  1       CS active (synchronised)
// BEHAVIOUR
//  - Reset: FSM IDLE; FIFO empty; io_rx_valid=0, io_rx_data=0, io_tx_ready=0, io_spi_miso=0, io_overrun=0, io_busy=0; bit count 0.
//  - sclk/cs/mosi go through SYNC_STAGES flops; sclk edges detected on synced value. Requires sclk period >=8 clock cycles.
//  - Leading edge = sclk leaving CPOL; trailing edge = sclk returning to CPOL. Mode latched at CS fall.
//  - CPHA=0: sample MOSI on leading; shift MISO on trailing edges.
//  - CPHA=1: shift MISO on leading edges; sample on trailing. First leading edge of a word exposes the loaded MSB (no shift).
//  - CPHA=0: the trailing edge after the WORD_W-th sample reloads TX instead of shifting.
//  - FSM: IDLE -(cs fall)-> LOAD (1 cycle) -> SHIFT -(WORD_W samples)-> PUSH (1 cycle) -> SHIFT.
//    Any state -(cs high)-> IDLE.
//  - LOAD/PUSH: TX shift register <= io_tx_data with io_tx_ready=1 if io_tx_valid, else <= TX_IDLE.
//    PUSH also writes the RX word and clears the bit count.
//  - io_spi_miso = tx_shift[WORD_W-1] while busy; 0 in IDLE.
//  - Latency: last sampling edge at pin -> io_rx_valid high within SYNC_STAGES+3 cycles.
//  - FIFO full at PUSH: word dropped, io_overrun<=1. Pop and push in the same cycle when full: both happen, no overrun.
//  - io_overrun_clr and a new overrun in the same cycle: set wins.
//  - CS rises mid-word: partial word discarded, no push, bit count 0, any accepted TX word lost; FIFO contents kept.
//  - FIFO is first-word-fall-through. Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty come from the MSB compare.
//  - io_mode changes while busy are ignored until the next CS fall.
// CONFIGURATION
//  SPI_DROP_COUNT_EN defined: adds port io_drop_count (out, 8), counting dropped RX words.
//   - Saturates at 255; cleared by io_overrun_clr (increment wins if same cycle); reset 0.
//  Undefined: port and counter absent; io_overrun unchanged.
// STRUCTURE
//  - spi_pkg: spi_mode_t {MODE0..MODE3}; spi_state_e {IDLE,LOAD,SHIFT,PUSH}; CPOL/CPHA bit-index constants.
//  - Sub-module spi_rx_fifo (#WIDTH,#DEPTH): sync FWFT FIFO with push/pop/full/empty.
//  - Synchroniser, edge detect, FSM and shift registers stay in this module.
// TESTING
//  - Mode 0, sclk 500 ns, words 0x0000,0x0000,0x0064,0x0064 back-to-back -> rx pops 0x0000,0x0000,0x0064,0x0064 in order; overrun=0.
//  - Modes 1/2/3: tx_data=0xA5C3 valid, master sends 0x1234 -> MISO bits 0xA5C3 MSB-first on correct edges; rx=0x1234; one tx_ready pulse.
//  - io_rx_ready=0, send FIFO_DEPTH+1 words -> 8 held, 9th dropped, io_overrun=1.
//    With SPI_DROP_COUNT_EN: io_drop_count=1.
//    Pop one and send again -> accepted.
//  - CS high after 7 bits, then full word 0xBEEF -> exactly one rx word 0xBEEF.
//  - No tx_valid for 2 words -> MISO sends TX_IDLE twice.
//    io_aresetn low mid-word -> all outputs at reset values.
//    Next word after release -> received correctly.
//  - Overrun clear vs new overrun in the same cycle -> io_overrun stays 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI slave stream block.
// Mode encoding is {CPOL,CPHA}; state names follow the word FSM.
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0,
    MODE1,
    MODE2,
    MODE3
  } spi_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    PUSH
  } spi_state_e;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through RX FIFO with wrap-bit pointers.
// A push on a full FIFO is accepted only when a pop happens in that cycle.
module spi_rx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Head reads as zero when empty so the stream data is clean out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave, oversampled on clock, all four modes, FIFO-backed RX stream.
// Optional SPI_DROP_COUNT_EN adds io_drop_count (dropped RX words).
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [WORD_W-1:0] TX_IDLE = '0
) (
  input  logic              clock,
  input  logic              io_aresetn,
  input  logic [1:0]        io_mode,
  input  logic              io_spi_sclk,
  input  logic              io_spi_cs,
  input  logic              io_spi_mosi,
  output logic              io_spi_miso,
  output logic [WORD_W-1:0] io_rx_data,
  output logic              io_rx_valid,
  input  logic              io_rx_ready,
  input  logic [WORD_W-1:0] io_tx_data,
  input  logic              io_tx_valid,
  output logic              io_tx_ready,
  output logic              io_overrun,
  input  logic              io_overrun_clr,
  output logic              io_busy
`ifdef SPI_DROP_COUNT_EN
  ,
  output logic [7:0]        io_drop_count
`endif
);

  localparam int CW = $clog2(WORD_W);

  logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
  logic                   sclk_s, cs_s, mosi_s, sclk_d;
  spi_state_e             state, state_n;
  spi_mode_t              mode_q;
  logic                   cpol, cpha;
  logic                   lead, trail;
  logic                   sample, shift;
  logic                   load, push, skip;
  logic [CW-1:0]          bit_cnt;
  logic [WORD_W-1:0]      tx_shift, rx_shift;
  logic                   fifo_full, fifo_empty;
  logic                   pop, drop;

  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      sclk_sr <= '0;
      cs_sr   <= '1;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], io_spi_sclk};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], io_spi_cs};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], io_spi_mosi};
      sclk_d  <= sclk_s;
    end
  end

  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign cs_s   = cs_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  assign cpol   = mode_q[CPOL_BIT];
  assign cpha   = mode_q[CPHA_BIT];
  assign lead   = (sclk_s != cpol) && (sclk_d == cpol);
  assign trail  = (sclk_s == cpol) && (sclk_d != cpol);
  assign sample = cpha ? trail : lead;
  assign shift  = cpha ? lead : trail;

  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      state  <= IDLE;
      mode_q <= MODE0;
    end else begin
      state <= state_n;
      if (state == IDLE && cs_s) mode_q <= spi_mode_t'(io_mode);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (!cs_s) state_n = LOAD;
      LOAD:  state_n = SHIFT;
      SHIFT: if (sample && bit_cnt == CW'(WORD_W - 1))
               state_n = PUSH;
      PUSH:  state_n = SHIFT;
      default: state_n = IDLE;
    endcase
    if (cs_s) state_n = IDLE;
  end

  assign load        = (state == LOAD) || (state == PUSH);
  assign push        = (state == PUSH);
  assign io_tx_ready = load && io_tx_valid;

  // skip swallows the one shift edge that would clobber a fresh load.
  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      skip     <= 1'b0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
      skip    <= 1'b0;
    end else begin
      if (load) begin
        tx_shift <= io_tx_valid ? io_tx_data : TX_IDLE;
        skip     <= cpha || push;
      end else if (shift) begin
        if (skip) skip <= 1'b0;
        else tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
      end
      if (push) begin
        bit_cnt <= '0;
      end else if (state == SHIFT && sample) begin
        rx_shift <= {rx_shift[WORD_W-2:0], mosi_s};
        bit_cnt  <= bit_cnt + CW'(1);
      end
    end
  end

  assign io_busy     = (state != IDLE);
  assign io_spi_miso = io_busy ? tx_shift[WORD_W-1] : 1'b0;

  assign io_rx_valid = !fifo_empty;
  assign pop         = io_rx_ready && io_rx_valid;
  assign drop        = push && fifo_full && !pop;

  spi_rx_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clock),
    .rst_n(io_aresetn),
    .push (push),
    .pop  (pop),
    .wdata(rx_shift),
    .rdata(io_rx_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) io_overrun <= 1'b0;
    else if (drop) io_overrun <= 1'b1;
    else if (io_overrun_clr) io_overrun <= 1'b0;
  end

`ifdef SPI_DROP_COUNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (io_overrun_clr) begin
      drop_cnt <= '0;
    end
  end

  assign io_drop_count = drop_cnt;
`endif

endmodule

// File: tb/tb_spi_slave_stream.sv
// Bench for spi_slave_stream: bit-level SPI master plus queue model.
// Build with SPI_DROP_COUNT_EN to also check io_drop_count.
`timescale 1ns/1ps
module tb_spi_slave_stream;

  localparam int W = 16;
  localparam int D = 8;
  localparam int SYN = 2;
  localparam logic [15:0] TXI = 16'h0000;

  logic        clock = 0;
  logic        rstn = 0;
  logic [1:0]  mode = 0;
  logic        sclk = 0;
  logic        cs = 1;
  logic        mosi = 0;
  logic        miso;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 0;
  logic [15:0] tx_data = 0;
  logic        tx_valid = 0;
  logic        tx_ready;
  logic        overrun;
  logic        ov_clr = 0;
  logic        busy;
`ifdef SPI_DROP_COUNT_EN
  logic [7:0]  drop_cnt;
`endif

  always #5 clock = ~clock;

  spi_slave_stream #(
    .WORD_W(W),
    .FIFO_DEPTH(D),
    .SYNC_STAGES(SYN),
    .TX_IDLE(TXI)
  ) dut (
    .clock(clock),
    .io_aresetn(rstn),
    .io_mode(mode),
    .io_spi_sclk(sclk),
    .io_spi_cs(cs),
    .io_spi_mosi(mosi),
    .io_spi_miso(miso),
    .io_rx_data(rx_data),
    .io_rx_valid(rx_valid),
    .io_rx_ready(rx_ready),
    .io_tx_data(tx_data),
    .io_tx_valid(tx_valid),
    .io_tx_ready(tx_ready),
    .io_overrun(overrun),
    .io_overrun_clr(ov_clr),
    .io_busy(busy)
`ifdef SPI_DROP_COUNT_EN
    ,
    .io_drop_count(drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rx[$];
  logic [15:0] pop_log[$];
  logic [15:0] txq[$];
  logic [15:0] exp_tx[$];
  logic [15:0] miso_log[$];
  logic [15:0] mq[$];
  bit ov_m = 0;
  int drop_m = 0;
  int txr_cnt = 0;
  int txr_m = 0;
  int half = 250;
  bit lat_chk = 0;
  int rdy_mode = 0;
  int pop_req = 0;
  int pop_done = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Single driver of rx_ready: fixed, random, or one-shot pops.
  always @(posedge clock) begin
    #2;
    if (pop_done != pop_req) begin
      rx_ready = 1'b1;
      pop_done++;
    end else if (rdy_mode == 2) begin
      rx_ready = 1'($urandom_range(0, 1));
    end else begin
      rx_ready = (rdy_mode == 1);
    end
  end

  // TX feeder: offers the head of txq, drops it once accepted.
  initial begin
    bit acc;
    forever begin
      @(negedge clock);
      acc = tx_ready;
      @(posedge clock);
      #1;
      if (acc && txq.size() > 0) begin
        void'(txq.pop_front());
        txr_cnt++;
      end
      tx_valid = (txq.size() > 0);
      tx_data = tx_valid ? txq[0] : 16'h0;
    end
  end

  // Compare process: FIFO head and pops against the model queue.
  always @(negedge clock) begin
    if (rstn && rx_valid) begin
      if (exp_rx.size() == 0) begin
        chk("rx_valid_unexpected", 1, 0);
      end else begin
        chk("rx_head", rx_data, exp_rx[0]);
        if (rx_ready) begin
          pop_log.push_back(rx_data);
          void'(exp_rx.pop_front());
        end
      end
    end
  end

  task automatic offer(input logic [15:0] w);
    txq.push_back(w);
    exp_tx.push_back(w);
  endtask

  task automatic mpush(input logic [15:0] w);
    if (exp_rx.size() < D) begin
      exp_rx.push_back(w);
    end else begin
      ov_m = 1;
      if (drop_m < 255) drop_m++;
    end
    if (lat_chk) begin
      fork
        begin
          repeat (SYN + 3) @(posedge clock);
          #1 chk("rx_latency", rx_valid, 1);
        end
      join_none
    end
  endtask

  task automatic next_tx(output logic [15:0] e);
    if (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      txr_m++;
    end else begin
      e = TXI;
    end
  endtask

  task automatic reset_checks();
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_miso", miso, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
`ifdef SPI_DROP_COUNT_EN
    chk("rst_drop_count", drop_cnt, 0);
`endif
  endtask

  // Sends all of mq in one CS frame; cut>=0 ends the frame after cut bits.
  task automatic burst(input logic [1:0] m, input int cut,
                       input bit do_rst);
    bit cpol, cpha, done;
    logic [15:0] w, e, got;
    int nbits;
    cpol = m[1];
    cpha = m[0];
    done = 0;
    nbits = 0;
    got = '0;
    mode = m;
    sclk = cpol;
    #(half);
    cs = 0;
    #(half);
    mode = 2'($urandom_range(0, 3));
    while (mq.size() > 0 && !done) begin
      w = mq.pop_front();
      next_tx(e);
      for (int b = W - 1; b >= 0; b--) begin
        if (nbits == cut) begin
          done = 1;
          break;
        end
        if (!cpha) begin
          mosi = w[b];
          #(half);
          got[b] = miso;
          sclk = ~cpol;
          if (b == 0) mpush(w);
          #(half);
          sclk = cpol;
        end else begin
          sclk = ~cpol;
          mosi = w[b];
          #(half);
          got[b] = miso;
          sclk = cpol;
          if (b == 0) mpush(w);
          #(half);
        end
        nbits++;
      end
      if (!done) begin
        miso_log.push_back(got);
        chk("miso_word", got, e);
      end
    end
    if (done && do_rst) begin
      rstn = 0;
      #1;
      reset_checks();
      exp_rx.delete();
      ov_m = 0;
      drop_m = 0;
    end
    if (!done) next_tx(e);
    #(half);
    cs = 1;
    sclk = cpol;
    #(half);
    if (do_rst) begin
      #100;
      rstn = 1;
    end
    #200;
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 200 && exp_rx.size() > 0; i++)
      @(posedge clock);
    repeat (4) @(posedge clock);
    chk("drain_empty", exp_rx.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [1:0] m;
    #1;
    reset_checks();
    #40;
    rstn = 1;
    repeat (5) @(posedge clock);

    // Mode 0 back-to-back, nothing offered on TX.
    rdy_mode = 1;
    half = 250;
    mq = '{16'h0000, 16'h0000, 16'h0064, 16'h0064};
    burst(2'd0, -1, 0);
    drain();
    chk("m0_pops", pop_log.size(), 4);
    chk("m0_pop0", pop_log[0], 16'h0000);
    chk("m0_pop2", pop_log[2], 16'h0064);
    chk("m0_pop3", pop_log[3], 16'h0064);
    chk("tx_idle_0", miso_log[0], TXI);
    chk("tx_idle_1", miso_log[1], TXI);
    chk("m0_overrun", overrun, 0);

    // Modes 1..3 full duplex with one offered TX word.
    for (int k = 1; k < 4; k++) begin
      pop_log.delete();
      miso_log.delete();
      t0 = txr_cnt;
      offer(16'hA5C3);
      repeat (4) @(posedge clock);
      mq = '{16'h1234};
      burst(2'(k), -1, 0);
      drain();
      chk("mode_miso", miso_log[0], 16'hA5C3);
      chk("mode_rx", pop_log[0], 16'h1234);
      chk("mode_tx_ready", txr_cnt - t0, 1);
    end

    // Overrun: nine words with no pops.
    rdy_mode = 0;
    repeat (4) @(posedge clock);
    for (int i = 0; i < D + 1; i++) mq.push_back(16'($urandom));
    burst(2'd0, -1, 0);
    chk("ovr_held", exp_rx.size(), 8);
    chk("ovr_flag", overrun, 1);
    chk("ovr_model", ov_m, 1);
`ifdef SPI_DROP_COUNT_EN
    chk("ovr_drop_count", drop_cnt, 1);
`endif
    pop_req++;
    repeat (4) @(posedge clock);
    mq = '{16'h0F0F};
    burst(2'd0, -1, 0);
    chk("ovr_refill", exp_rx.size(), 8);
    chk("ovr_sticky", overrun, 1);
    @(posedge clock);
    #2 ov_clr = 1;
    @(posedge clock);
    #2 ov_clr = 0;
    ov_m = 0;
    drop_m = 0;
    #1 chk("ovr_cleared", overrun, 0);

    // Clear held high while a new overrun lands: set must win.
    ov_clr = 1;
    mq = '{16'h3C3C};
    fork
      burst(2'd0, -1, 0);
    join_none
    for (int i = 0; i < 3000 && !overrun; i++) @(negedge clock);
    ov_clr = 0;
    wait fork;
    chk("clr_vs_set", overrun, 1);
`ifdef SPI_DROP_COUNT_EN
    chk("clr_vs_set_cnt", drop_cnt, 8'(drop_m));
`endif
    drain();
    pop_log.delete();

    // Abort after 7 bits, then a full word.
    rdy_mode = 0;
    mq = '{16'h5555};
    burst(2'd0, 7, 0);
    lat_chk = 1;
    mq = '{16'hBEEF};
    burst(2'd0, -1, 0);
    lat_chk = 0;
    chk("abort_count", exp_rx.size(), 1);
    chk("abort_head", rx_data, 16'hBEEF);
    pop_req++;
    repeat (4) @(posedge clock);
    chk("abort_single", rx_valid, 0);

    // Reset in the middle of a mode-3 word, then a clean word.
    offer(16'h5A5A);
    repeat (4) @(posedge clock);
    mq = '{16'h7777};
    burst(2'd3, 9, 1);
    pop_log.delete();
    rdy_mode = 1;
    mq = '{16'hC0DE};
    burst(2'd3, -1, 0);
    drain();
    chk("post_rst_rx", pop_log[0], 16'hC0DE);

    // Randomized frames: modes, words, TX offers and pop pressure.
    half = 80;
    rdy_mode = 2;
    for (int f = 0; f < 10; f++) begin
      m = 2'($urandom_range(0, 3));
      for (int i = 0; i < $urandom_range(0, 3); i++)
        offer(16'($urandom));
      repeat (4) @(posedge clock);
      for (int i = 0; i < $urandom_range(1, 3); i++)
        mq.push_back(16'($urandom));
      burst(m, -1, 0);
    end
    drain();
    repeat (8) @(posedge clock);
    chk("rand_tx_ready", txr_cnt, txr_m);
    chk("rand_overrun", overrun, ov_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
